// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, keeps one request outstanding to instruction memory, parks a
// returned word in a skid register during a load-use stall, and drains a
// stale request after a redirect. Squashed IF/ID slots carry the canonical
// NOP (addi x0,x0,0).
// Optional feature: define FETCH_MISALIGN_TRAP_EN to send redirects with a
// non-word-aligned target to TRAP_VECTOR and pulse fetch_misalign.
`timescale 1ns/1ps

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
   , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] if_id_ir,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        fetch_misalign
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] drain_pc_r, drain_pc_s;
   logic [31:0] skid_ir_r, skid_ir_s;
   logic [31:0] skid_pc_r, skid_pc_s;
   logic [31:0] ir_r, ir_s;
   logic [31:0] ifpc_r, ifpc_s;
   logic [31:0] ifpc4_r, ifpc4_s;
   logic        ifvalid_r, ifvalid_s;
   logic        misalign_r, misalign_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] target_s;
   logic        target_bad_s;

   // PC arithmetic wraps naturally at 32 bits.
   assign pc_plus4_s = pc_r + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   // A misaligned target is replaced by the trap vector.
   assign target_bad_s = (redirect_pc[1:0] != 2'b00);
   assign target_s     = target_bad_s ? TRAP_VECTOR : redirect_pc;
`else
   // Without the trap the low two target bits are simply dropped.
   assign target_bad_s = 1'b0;
   assign target_s     = redirect_pc & 32'hFFFF_FFFC;
`endif

   // Memory interface is decoded from registered state only; DRAIN keeps the
   // stale address stable until the abandoned request completes.
   assign imem_req  = (state_r == FETCH) || (state_r == DRAIN);
   assign imem_addr = (state_r == DRAIN) ? drain_pc_r : pc_r;

   assign if_id_ir       = ir_r;
   assign if_id_pc       = ifpc_r;
   assign if_id_pc4      = ifpc4_r;
   assign if_id_valid    = ifvalid_r;
   assign fetch_misalign = misalign_r;

   // Next-state and datapath decode; redirect outranks stall and imem_valid.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      drain_pc_s = drain_pc_r;
      skid_ir_s  = skid_ir_r;
      skid_pc_s  = skid_pc_r;
      ir_s       = ir_r;
      ifpc_s     = ifpc_r;
      ifpc4_s    = ifpc4_r;
      ifvalid_s  = ifvalid_r;
      misalign_s = 1'b0;
      if (redirect) begin
         ir_s       = NOP;
         ifvalid_s  = 1'b0;
         pc_s       = target_s;
         misalign_s = target_bad_s;
         case (state_r)
            FETCH: begin
               if (imem_valid) begin
                  state_s = FETCH;
               end else begin
                  state_s    = DRAIN;
                  drain_pc_s = pc_r;
               end
            end
            DRAIN: begin
               if (imem_valid) begin
                  state_s = FETCH;
               end else begin
                  state_s = DRAIN;
               end
            end
            default: state_s = FETCH;
         endcase
      end else begin
         case (state_r)
            IDLE: begin
               state_s = FETCH;
               if (!stall) begin
                  ir_s      = NOP;
                  ifvalid_s = 1'b0;
               end else begin
                  ifvalid_s = ifvalid_r;
               end
            end
            FETCH: begin
               if (imem_valid && !stall) begin
                  ir_s      = imem_rdata;
                  ifpc_s    = pc_r;
                  ifpc4_s   = pc_plus4_s;
                  ifvalid_s = 1'b1;
                  pc_s      = pc_plus4_s;
                  state_s   = FETCH;
               end else if (imem_valid) begin
                  skid_ir_s = imem_rdata;
                  skid_pc_s = pc_r;
                  pc_s      = pc_plus4_s;
                  state_s   = HOLD;
               end else if (!stall) begin
                  ir_s      = NOP;
                  ifvalid_s = 1'b0;
               end else begin
                  state_s = FETCH;
               end
            end
            HOLD: begin
               if (!stall) begin
                  ir_s      = skid_ir_r;
                  ifpc_s    = skid_pc_r;
                  ifpc4_s   = skid_pc_r + 32'd4;
                  ifvalid_s = 1'b1;
                  state_s   = FETCH;
               end else begin
                  state_s = HOLD;
               end
            end
            DRAIN: begin
               if (imem_valid) begin
                  state_s = FETCH;
               end else begin
                  state_s = DRAIN;
               end
               if (!stall) begin
                  ir_s      = NOP;
                  ifvalid_s = 1'b0;
               end else begin
                  ifvalid_s = ifvalid_r;
               end
            end
            default: begin
               state_s   = IDLE;
               ir_s      = NOP;
               ifvalid_s = 1'b0;
            end
         endcase
      end
   end

   // State and pipeline registers; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         pc_r       <= RESET_PC;
         drain_pc_r <= RESET_PC;
         skid_ir_r  <= NOP;
         skid_pc_r  <= 32'h0000_0000;
         ir_r       <= NOP;
         ifpc_r     <= 32'h0000_0000;
         ifpc4_r    <= 32'h0000_0000;
         ifvalid_r  <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         drain_pc_r <= drain_pc_s;
         skid_ir_r  <= skid_ir_s;
         skid_pc_r  <= skid_pc_s;
         ir_r       <= ir_s;
         ifpc_r     <= ifpc_s;
         ifpc4_r    <= ifpc4_s;
         ifvalid_r  <= ifvalid_s;
         misalign_r <= misalign_s;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run of fetch_stage
// against a flag-based behavioural model of the fetch rules. Memory returns
// addr|0x13 after a programmable number of wait cycles.
`timescale 1ns/1ps

module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR = 32'h0000_0004;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] if_id_ir;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fetch_misalign;

   int tests_run = 0;
   int tests_failed = 0;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .if_id_ir(if_id_ir), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
      .fetch_misalign(fetch_misalign)
   );

   always #5 clk = ~clk;

   // ---------------- memory model: wait cycles then addr|0x13 ----------------
   int cnt;
   int lat_fixed = 0;
   int lat_rnd;
   bit lat_rand_en = 1'b0;
   int lat_eff;
   assign lat_eff    = lat_rand_en ? lat_rnd : lat_fixed;
   assign imem_valid = imem_req && (cnt >= lat_eff);
   assign imem_rdata = imem_addr | 32'h0000_0013;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= 0;
         lat_rnd <= 0;
      end else begin
         if (imem_req && !imem_valid) cnt <= cnt + 1;
         else cnt <= 0;
         if (imem_req && imem_valid) lat_rnd <= int'($urandom_range(0, 2));
      end
   end

   // ---------------- behavioural reference model ----------------
   typedef struct packed {
      logic        started;   // first post-reset cycle has passed
      logic        parked;    // a fetched word waits for the stall to clear
      logic        disc;      // an abandoned request is still in flight
      logic [31:0] pc;
      logic [31:0] dpc;
      logic [31:0] pk_ir;
      logic [31:0] pk_pc;
      logic [31:0] ir;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic        iv;
      logic        mis;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t mreset();
      mstate_t r;
      r = '0;
      r.pc  = RESET_PC;
      r.dpc = RESET_PC;
      r.ir  = NOP;
      return r;
   endfunction

   function automatic mstate_t mnext(mstate_t s, logic st, logic rd, logic [31:0] rpc, logic v);
      mstate_t n;
      logic req;
      logic bad;
      logic [31:0] tgt;
      n = s;
      n.mis = 1'b0;
      n.started = 1'b1;
      req = s.started && !s.parked;
`ifdef FETCH_MISALIGN_TRAP_EN
      bad = (rpc % 4) != 0;
      tgt = bad ? TRAP_VECTOR : rpc;
`else
      bad = 1'b0;
      tgt = rpc - (rpc % 4);
`endif
      if (rd) begin
         n.iv = 1'b0; n.ir = NOP; n.parked = 1'b0; n.pc = tgt; n.mis = bad;
         if (s.disc) n.disc = !v;
         else if (req && !v) begin n.disc = 1'b1; n.dpc = s.pc; end
      end else if (s.disc) begin
         if (!st) begin n.iv = 1'b0; n.ir = NOP; end
         if (v) n.disc = 1'b0;
      end else if (!s.started) begin
         if (!st) begin n.iv = 1'b0; n.ir = NOP; end
      end else if (s.parked) begin
         if (!st) begin
            n.iv = 1'b1; n.ir = s.pk_ir; n.ipc = s.pk_pc; n.ipc4 = s.pk_pc + 4; n.parked = 1'b0;
         end
      end else if (v) begin
         if (!st) begin
            n.iv = 1'b1; n.ir = s.pc | 32'h13; n.ipc = s.pc; n.ipc4 = s.pc + 4;
         end else begin
            n.parked = 1'b1; n.pk_ir = s.pc | 32'h13; n.pk_pc = s.pc;
         end
         n.pc = s.pc + 4;
      end else if (!st) begin
         n.iv = 1'b0; n.ir = NOP;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) m <= mreset();
      else m <= mnext(m, stall, redirect, redirect_pc, imem_valid);
   end

   logic        exp_req;
   logic [31:0] exp_addr;
   always_comb begin
      exp_req  = m.started && !m.parked;
      exp_addr = m.disc ? m.dpc : m.pc;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; lat_fixed = 0; lat_rand_en = 1'b0;
      tick(); tick();
      tests_run += 7;
      if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %b want 0", imem_req); end
      if (imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL rst_addr got %h want %h", imem_addr, RESET_PC); end
      if (if_id_ir !== NOP) begin tests_failed++; $display("FAIL rst_ir got %h want %h", if_id_ir, NOP); end
      if (if_id_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_pc got %h want 0", if_id_pc); end
      if (if_id_pc4 !== 32'h0) begin tests_failed++; $display("FAIL rst_pc4 got %h want 0", if_id_pc4); end
      if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
      if (fetch_misalign !== 1'b0) begin tests_failed++; $display("FAIL rst_mis got %b want 0", fetch_misalign); end
      rst = 1'b1;
      tests_run++;
      if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL idle_req got %b want 0", imem_req); end
      tick();
      tests_run += 2;
      if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL start_req got %b want 1", imem_req); end
      if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL start_addr got %h want 0", imem_addr); end
      tick();
      tests_run += 4;
      if (if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid got %b want 1", if_id_valid); end
      if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin tests_failed++; $display("FAIL first_pc got %h/%h want 0/4", if_id_pc, if_id_pc4); end
      if (if_id_ir !== 32'h13) begin tests_failed++; $display("FAIL first_ir got %h want 13", if_id_ir); end
      if (imem_addr !== 32'h4) begin tests_failed++; $display("FAIL second_addr got %h want 4", imem_addr); end
      tick();
      tests_run += 2;
      if (if_id_pc !== 32'h4 || if_id_pc4 !== 32'h8 || if_id_ir !== 32'h17) begin tests_failed++; $display("FAIL second_slot got %h/%h/%h want 4/8/17", if_id_pc, if_id_pc4, if_id_ir); end
      if (imem_addr !== 32'h8) begin tests_failed++; $display("FAIL third_addr got %h want 8", imem_addr); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run += 2;
         if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_freeze got pc %h v %b want 4/1", if_id_pc, if_id_valid); end
         if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL hold_req got %b want 0", imem_req); end
      end
      stall = 1'b0;
      tick();
      tests_run += 2;
      if (if_id_pc !== 32'h8 || if_id_ir !== 32'h1b || if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_out got %h/%h/%b want 8/1b/1", if_id_pc, if_id_ir, if_id_valid); end
      if (imem_addr !== 32'hC || imem_req !== 1'b1) begin tests_failed++; $display("FAIL after_hold_addr got %h/%b want c/1", imem_addr, imem_req); end
      tick();
      tests_run++;
      if (if_id_pc !== 32'hC || if_id_ir !== 32'h1f) begin tests_failed++; $display("FAIL after_skid got %h/%h want c/1f", if_id_pc, if_id_ir); end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0; stall = 1'b0;
      tests_run += 2;
      if (if_id_valid !== 1'b0 || if_id_ir !== NOP) begin tests_failed++; $display("FAIL redir_bubble got %b/%h want 0/13", if_id_valid, if_id_ir); end
      if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL redir_addr got %h/%b want 100/1", imem_addr, imem_req); end
      tick();
      tests_run++;
      if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL redir_target got %h/%b want 100/1", if_id_pc, if_id_valid); end
      tick();
      tests_run++;
      if (if_id_pc !== 32'h104) begin tests_failed++; $display("FAIL redir_next got %h want 104", if_id_pc); end
   endtask

   task automatic test_drain();
      lat_fixed = 1;
      redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      tests_run += 2;
      if (imem_addr !== 32'h108 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL drain_addr got %h/%b want 108/1", imem_addr, imem_req); end
      if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_bubble got %b want 0", if_id_valid); end
      tick();
      tests_run += 2;
      if (imem_addr !== 32'h200) begin tests_failed++; $display("FAIL drain_exit_addr got %h want 200", imem_addr); end
      if (if_id_valid !== 1'b0 || if_id_ir !== NOP) begin tests_failed++; $display("FAIL drain_stale got %b/%h want 0/13", if_id_valid, if_id_ir); end
      tick();
      tests_run++;
      if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_wait got %b want 0", if_id_valid); end
      tick();
      tests_run++;
      if (if_id_pc !== 32'h200 || if_id_ir !== 32'h213 || if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL drain_target got %h/%h/%b want 200/213/1", if_id_pc, if_id_ir, if_id_valid); end
   endtask

   task automatic test_wrap();
      lat_fixed = 0;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      tests_run++;
      if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
      tick();
      tests_run += 2;
      if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4 got %h/%h want fffffffc/0", if_id_pc, if_id_pc4); end
      if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next got %h want 0", imem_addr); end
   endtask

   task automatic test_misalign();
      logic [31:0] want_addr;
      logic        want_mis;
`ifdef FETCH_MISALIGN_TRAP_EN
      want_addr = TRAP_VECTOR; want_mis = 1'b1;
`else
      want_addr = 32'h100; want_mis = 1'b0;
`endif
      redirect = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
      tests_run += 2;
      if (imem_addr !== want_addr) begin tests_failed++; $display("FAIL mis_addr got %h want %h", imem_addr, want_addr); end
      if (fetch_misalign !== want_mis) begin tests_failed++; $display("FAIL mis_pulse got %b want %b", fetch_misalign, want_mis); end
      tick();
      tests_run += 2;
      if (fetch_misalign !== 1'b0) begin tests_failed++; $display("FAIL mis_one_cycle got %b want 0", fetch_misalign); end
      if (if_id_pc !== want_addr) begin tests_failed++; $display("FAIL mis_target got %h want %h", if_id_pc, want_addr); end
   endtask

   task automatic test_random();
      int n_del = 0;
      logic [31:0] r;
      lat_rand_en = 1'b1;
      for (int i = 0; i < 800; i++) begin
         tick();
         tests_run += 6;
         if (imem_req !== exp_req) begin tests_failed++; $display("FAIL rnd_req cyc %0d got %b want %b", i, imem_req, exp_req); end
         if (exp_req && imem_addr !== exp_addr) begin tests_failed++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, imem_addr, exp_addr); end
         if (if_id_valid !== m.iv) begin tests_failed++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, if_id_valid, m.iv); end
         if (if_id_ir !== m.ir) begin tests_failed++; $display("FAIL rnd_ir cyc %0d got %h want %h", i, if_id_ir, m.ir); end
         if (if_id_pc !== m.ipc || if_id_pc4 !== m.ipc4) begin tests_failed++; $display("FAIL rnd_pc cyc %0d got %h/%h want %h/%h", i, if_id_pc, if_id_pc4, m.ipc, m.ipc4); end
         if (fetch_misalign !== m.mis) begin tests_failed++; $display("FAIL rnd_mis cyc %0d got %b want %b", i, fetch_misalign, m.mis); end
         if (if_id_valid === 1'b1) n_del++;
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 9) == 0);
         r = $urandom;
         case ($urandom_range(0, 3))
            0: redirect_pc = r & 32'h0000_0FFC;
            1: redirect_pc = r & 32'h0000_0FFF;
            2: redirect_pc = 32'hFFFF_FFF0 | (r & 32'h0000_000C);
            default: redirect_pc = r;
         endcase
      end
      stall = 1'b0; redirect = 1'b0; lat_rand_en = 1'b0;
      tests_run++;
      if (n_del < 50) begin tests_failed++; $display("FAIL rnd_progress got %0d deliveries want >= 50", n_del); end
   endtask

   task automatic test_mid_reset();
      lat_fixed = 3;
      tick(); tick();
      #2 rst = 1'b0;
      #1;
      tests_run += 3;
      if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL mrst_req got %b want 0", imem_req); end
      if (if_id_valid !== 1'b0 || if_id_ir !== NOP) begin tests_failed++; $display("FAIL mrst_ifid got %b/%h want 0/13", if_id_valid, if_id_ir); end
      if (imem_addr !== RESET_PC) begin tests_failed++; $display("FAIL mrst_addr got %h want %h", imem_addr, RESET_PC); end
      lat_fixed = 0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_pc !== RESET_PC) begin tests_failed++; $display("FAIL mrst_restart got %b/%h want 1/%h", if_id_valid, if_id_pc, RESET_PC); end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect_stall();
      test_drain();
      test_wrap();
      test_misalign();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
